// File: rtl/riscv_pkg.sv
// Shared RV32I control encodings: FSM states, opcodes, ALU codes and datapath select values.
// Used by multicycle_control, alu_decoder and the single-cycle control.
package riscv_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// Maps the control's ALUOp request plus instruction funct fields to a 3-bit ALU operation.
// Shared between the single-cycle and multi-cycle control units.
module alu_decoder
  import riscv_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7b5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // op5 separates R-type sub from I-type addi, which has no sub form
          3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Moore FSM sequencing the shared-memory RV32I datapath over 3-5 cycles per instruction.
// Define MCCTRL_JAL_EN to compile in jal support; otherwise jal decodes as illegal.
module multicycle_control
  import riscv_pkg::*;
(
  input  logic       CLK,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic       RegWrite,
  output logic       illegal,
  output logic [3:0] state
);

  state_t     state_q, state_d, out_state;
  logic [1:0] alu_op;
  logic       pc_write_raw, mem_write_raw, ir_write_raw, reg_write_raw, illegal_raw;

  always_ff @(posedge CLK) begin
    if (!rst) state_q <= S_FETCH;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_BEQ:       state_d = S_BEQ;
`ifdef MCCTRL_JAL_EN
          OP_JAL:       state_d = S_JAL;
`endif
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:  state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD: state_d = S_MEMWB;
      S_EXECR, S_EXECI: state_d = S_ALUWB;
`ifdef MCCTRL_JAL_EN
      S_JAL:     state_d = S_ALUWB;
`endif
      default:   state_d = S_FETCH;
    endcase
  end

  // While in reset the selects present FETCH values so the datapath sees a quiet, known setup.
  assign out_state = rst ? state_q : S_FETCH;

  always_comb begin
    pc_write_raw  = 1'b0;
    AdrSrc        = 1'b0;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    illegal_raw   = 1'b0;
    ResultSrc     = RES_ALUOUT;
    ALUSrcA       = SRCA_PC;
    ALUSrcB       = SRCB_RS2;
    alu_op        = ALUOP_ADD;
    case (out_state)
      S_FETCH: begin
        ir_write_raw = 1'b1;
        pc_write_raw = 1'b1;
        ALUSrcB      = SRCB_FOUR;
        ResultSrc    = RES_ALURESULT;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (op)
          OP_LW, OP_SW, OP_R, OP_I, OP_BEQ: illegal_raw = 1'b0;
`ifdef MCCTRL_JAL_EN
          OP_JAL:  illegal_raw = 1'b0;
`endif
          default: illegal_raw = 1'b1;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc     = RES_DATA;
        reg_write_raw = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc        = 1'b1;
        mem_write_raw = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = SRCA_RS1;
        alu_op  = ALUOP_FUNCT;
      end
      S_EXECI: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        alu_op  = ALUOP_FUNCT;
      end
      S_ALUWB: reg_write_raw = 1'b1;
      S_BEQ: begin
        ALUSrcA      = SRCA_RS1;
        alu_op       = ALUOP_SUB;
        pc_write_raw = Zero;
      end
`ifdef MCCTRL_JAL_EN
      S_JAL: begin
        ALUSrcA      = SRCA_OLDPC;
        ALUSrcB      = SRCB_FOUR;
        pc_write_raw = 1'b1;
      end
`endif
      default: begin
        pc_write_raw = 1'b0;
      end
    endcase
  end

  assign PCWrite  = rst & pc_write_raw;
  assign MemWrite = rst & mem_write_raw;
  assign IRWrite  = rst & ir_write_raw;
  assign RegWrite = rst & reg_write_raw;
  assign illegal  = rst & illegal_raw;
  assign state    = state_q;

  always_comb begin
    case (op)
      OP_SW:   ImmSrc = IMM_S;
      OP_BEQ:  ImmSrc = IMM_B;
      OP_JAL:  ImmSrc = IMM_J;
      default: ImmSrc = IMM_I;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .op5         (op[5]),
    .funct7b5    (funct7b5),
    .alu_control (ALUControl)
  );

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed scenarios plus randomized instructions
// checked against an instruction-level model of the per-cycle control outputs.
module tb_multicycle_control;

  logic       CLK = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] state;

  int total = 0;
  int bad   = 0;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111;

`ifdef MCCTRL_JAL_EN
  localparam bit JAL_ON = 1'b1;
`else
  localparam bit JAL_ON = 1'b0;
`endif

  multicycle_control dut (
    .CLK(CLK), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Zero(Zero),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
    .ImmSrc(ImmSrc), .RegWrite(RegWrite), .illegal(illegal), .state(state)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Instruction class: 0 lw, 1 sw, 2 R, 3 I, 4 beq, 5 jal, 6 illegal
  function automatic int classify(logic [6:0] o);
    if (o == LW) return 0;
    if (o == SW) return 1;
    if (o == RT) return 2;
    if (o == IT) return 3;
    if (o == BQ) return 4;
    if (o == JL && JAL_ON) return 5;
    return 6;
  endfunction

  function automatic logic [2:0] funct_alu(logic [6:0] o, logic [2:0] f3, logic f7);
    case (f3)
      3'b000:  return (o == RT && f7) ? 3'd1 : 3'd0;
      3'b010:  return 3'd5;
      3'b110:  return 3'd3;
      3'b111:  return 3'd2;
      default: return 3'd0;
    endcase
  endfunction

  task automatic test_reset();
    int n;
    op = LW; rst = 1'b1;
    n = $urandom_range(1, 3);
    repeat (n) step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if ({PCWrite, IRWrite, RegWrite, MemWrite, illegal} !== 5'b0) begin
        bad++;
        $display("FAIL reset_we cyc=%0d got=%b want=00000", i, {PCWrite, IRWrite, RegWrite, MemWrite, illegal});
      end
      total++;
      if (ALUSrcB !== 2'b10 || ResultSrc !== 2'b10) begin
        bad++;
        $display("FAIL reset_sel cyc=%0d got srcb=%b res=%b want 10 10", i, ALUSrcB, ResultSrc);
      end
      step();
      total++;
      if (state !== 4'd0) begin
        bad++;
        $display("FAIL reset_state cyc=%0d got=%0d want=0", i, state);
      end
    end
    rst = 1'b1;
    #1;
    total++;
    if (state !== 4'd0 || IRWrite !== 1'b1 || PCWrite !== 1'b1) begin
      bad++;
      $display("FAIL reset_release got state=%0d ir=%b pc=%b want 0 1 1", state, IRWrite, PCWrite);
    end
  endtask

  task automatic test_lw();
    int seq[5] = '{0, 1, 2, 3, 4};
    op = LW; funct3 = 3'b010; Zero = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      total++;
      if (state !== seq[c][3:0] || RegWrite !== (c == 4) || AdrSrc !== (c == 3)) begin
        bad++;
        $display("FAIL lw cyc=%0d got st=%0d rw=%b adr=%b want st=%0d rw=%b adr=%b",
                 c, state, RegWrite, AdrSrc, seq[c], c == 4, c == 3);
      end
      if (c == 4) begin
        total++;
        if (ResultSrc !== 2'b01) begin
          bad++;
          $display("FAIL lw_result got=%b want=01", ResultSrc);
        end
      end
      step();
    end
  endtask

  task automatic test_sw();
    int seq[4] = '{0, 1, 2, 5};
    op = SW;
    for (int c = 0; c < 4; c++) begin
      #1;
      total++;
      if (state !== seq[c][3:0] || MemWrite !== (c == 3) || ImmSrc !== 2'b01) begin
        bad++;
        $display("FAIL sw cyc=%0d got st=%0d mw=%b imm=%b want st=%0d mw=%b imm=01",
                 c, state, MemWrite, ImmSrc, seq[c], c == 3);
      end
      step();
    end
  endtask

  task automatic test_rtype_sub();
    logic [6:0] ops[2] = '{RT, IT};
    logic [2:0] want[2] = '{3'b001, 3'b000};
    funct3 = 3'b000; funct7b5 = 1'b1;
    for (int k = 0; k < 2; k++) begin
      op = ops[k];
      step(); step();
      #1;
      total++;
      if (state !== (k == 0 ? 4'd6 : 4'd7) || ALUControl !== want[k]) begin
        bad++;
        $display("FAIL exec_sub op=%b got st=%0d alu=%b want alu=%b", op, state, ALUControl, want[k]);
      end
      step(); step();
    end
  endtask

  task automatic test_beq();
    op = BQ;
    for (int z = 0; z < 2; z++) begin
      step(); step();
      Zero = z[0];
      #1;
      total++;
      if (state !== 4'd9 || PCWrite !== z[0]) begin
        bad++;
        $display("FAIL beq zero=%0d got st=%0d pcw=%b want st=9 pcw=%0d", z, state, PCWrite, z);
      end
      step();
      total++;
      if (state !== 4'd0) begin
        bad++;
        $display("FAIL beq_next zero=%0d got=%0d want=0", z, state);
      end
    end
  endtask

  task automatic test_illegal();
    logic [6:0] ops[2] = '{7'b1111111, JL};
    for (int k = 0; k < 2; k++) begin
      bit ill;
      op = ops[k];
      ill = (k == 0) || !JAL_ON;
      step();
      #1;
      total++;
      if (state !== 4'd1 || illegal !== ill || RegWrite !== 1'b0 || MemWrite !== 1'b0) begin
        bad++;
        $display("FAIL illegal op=%b got st=%0d ill=%b rw=%b mw=%b want st=1 ill=%b rw=0 mw=0",
                 op, state, illegal, RegWrite, MemWrite, ill);
      end
      step();
      total++;
      if (state !== (ill ? 4'd0 : 4'd10) || illegal !== 1'b0) begin
        bad++;
        $display("FAIL illegal_next op=%b got st=%0d ill=%b want st=%0d ill=0",
                 op, state, illegal, ill ? 0 : 10);
      end
      if (!ill) begin
        step();
        total++;
        if (state !== 4'd8 || RegWrite !== 1'b1) begin
          bad++;
          $display("FAIL jal_wb got st=%0d rw=%b want st=8 rw=1", state, RegWrite);
        end
        step();
      end
    end
  endtask

  task automatic test_random();
    int lens[7] = '{5, 4, 4, 4, 3, 4, 2};
    logic [6:0] pool[6] = '{LW, SW, RT, IT, BQ, JL};
    for (int n = 0; n < 300; n++) begin
      int r, kind;
      r = $urandom_range(0, 7);
      if (r < 6) op = pool[r];
      else if (r == 6) op = 7'b1111111;
      else op = 7'($urandom);
      funct3 = 3'($urandom);
      funct7b5 = 1'($urandom);
      kind = classify(op);
      for (int c = 0; c < lens[kind]; c++) begin
        logic [3:0] e_st;
        logic       e_pcw, e_adr, e_mw, e_irw, e_rw, e_ill;
        logic [1:0] e_res, e_sa, e_sb, e_imm;
        logic [2:0] e_alu;
        logic [20:0] exp_v, act_v;
        Zero = 1'($urandom);
        #1;
        e_st = 0; e_pcw = 0; e_adr = 0; e_mw = 0; e_irw = 0; e_rw = 0; e_ill = 0;
        e_res = 0; e_sa = 0; e_sb = 0; e_alu = 0;
        e_imm = (op == SW) ? 2'd1 : (op == BQ) ? 2'd2 : (op == JL) ? 2'd3 : 2'd0;
        if (c == 0) begin
          e_pcw = 1; e_irw = 1; e_sb = 2; e_res = 2;
        end else if (c == 1) begin
          e_st = 1; e_sa = 1; e_sb = 1; e_ill = (kind == 6);
        end else if (c == 2) begin
          case (kind)
            0, 1: begin e_st = 2; e_sa = 2; e_sb = 1; end
            2:    begin e_st = 6; e_sa = 2; e_alu = funct_alu(op, funct3, funct7b5); end
            3:    begin e_st = 7; e_sa = 2; e_sb = 1; e_alu = funct_alu(op, funct3, funct7b5); end
            4:    begin e_st = 9; e_sa = 2; e_alu = 1; e_pcw = Zero; end
            default: begin e_st = 10; e_sa = 1; e_sb = 2; e_pcw = 1; end
          endcase
        end else if (c == 3) begin
          if (kind == 0)      begin e_st = 3; e_adr = 1; end
          else if (kind == 1) begin e_st = 5; e_adr = 1; e_mw = 1; end
          else                begin e_st = 8; e_rw = 1; end
        end else begin
          e_st = 4; e_res = 1; e_rw = 1;
        end
        exp_v = {e_st, e_pcw, e_adr, e_mw, e_irw, e_res, e_sa, e_sb, e_alu, e_imm, e_rw, e_ill};
        act_v = {state, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                 ALUControl, ImmSrc, RegWrite, illegal};
        total++;
        if (act_v !== exp_v) begin
          bad++;
          $display("FAIL random n=%0d op=%b f3=%b f7=%b z=%b cyc=%0d got=%b want=%b",
                   n, op, funct3, funct7b5, Zero, c, act_v, exp_v);
        end
        step();
      end
    end
  endtask

  initial begin
    rst = 1'b0; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; Zero = 1'b0;
    repeat (2) step();
    test_reset();
    test_lw();
    test_sw();
    test_rtype_sub();
    test_beq();
    test_illegal();
    test_random();
    test_reset();
    test_lw();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle control unit for the RV32I core: a Moore FSM that sequences one shared memory, one ALU and the register file over 3–5 cycles per instruction. It replaces the single-cycle combinational control when the datapath moves to a unified instruction/data memory. It drives the datapath mux selects and write enables from the opcode latched in the datapath's instruction register. It supports lw, sw, R-type ALU, I-type ALU, beq and (configurable) jal.

## Interface
Parameters:
- none; all encodings come from the shared package.

Ports:
- `CLK`  in  1  — single system clock; all state changes on its rising edge.
- `rst`  in  1  — synchronous, active-low reset.
- `op`  in  7  — `Instr[6:0]` from the instruction register.
- `funct3`  in  3  — `Instr[14:12]`.
- `funct7b5`  in  1  — `Instr[30]`.
- `Zero`  in  1  — ALU zero flag.
- `PCWrite`  out  1  — PC register enable.
- `AdrSrc`  out  1  — memory address select: 0 = PC, 1 = ALUOut.
- `MemWrite`  out  1  — memory write enable.
- `IRWrite`  out  1  — instruction register and OldPC enable.
- `ResultSrc`  out  2  — result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- `ALUSrcA`  out  2  — ALU A select: 00 = PC, 01 = OldPC, 10 = rs1.
- `ALUSrcB`  out  2  — ALU B select: 00 = rs2, 01 = ImmExt, 10 = constant 4.
- `ALUControl`  out  3  — ALU operation code.
- `ImmSrc`  out  2  — immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
- `RegWrite`  out  1  — register file write enable.
- `illegal`  out  1  — one-cycle pulse in DECODE when the opcode is unsupported.
- `state`  out  4  — current state, for debug and the bench.

## Operation
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BEQ 9, JAL 10.
- Transitions:
  - FETCH → DECODE.
  - DECODE → by `op`: lw/sw (0000011/0100011) → MEMADR; R-type (0110011) → EXECR; I-type (0010011) → EXECI; beq (1100011) → BEQ; jal (1101111) → JAL; any other opcode → FETCH with `illegal`=1.
  - MEMADR → MEMREAD if `op[5]`=0, else MEMWRITE.
  - MEMREAD → MEMWB.
  - EXECR, EXECI, JAL → ALUWB.
  - MEMWB, MEMWRITE, ALUWB, BEQ → FETCH.
  - Encodings 11–15 → FETCH.
- Per-state outputs (anything not listed is 0 or 00):
  - FETCH: IRWrite, PCWrite, ALUSrcB=10, ResultSrc=10; ALUOp add.
  - DECODE: ALUSrcA=01, ALUSrcB=01; ALUOp add (computes the branch target into ALUOut).
  - MEMADR: ALUSrcA=10, ALUSrcB=01; add.
  - MEMREAD: AdrSrc=1.
  - MEMWB: ResultSrc=01, RegWrite.
  - MEMWRITE: AdrSrc=1, MemWrite.
  - EXECR: ALUSrcA=10; ALUOp funct.
  - EXECI: ALUSrcA=10, ALUSrcB=01; ALUOp funct.
  - ALUWB: RegWrite.
  - BEQ: ALUSrcA=10; ALUOp sub; PCWrite = `Zero`.
  - JAL: ALUSrcA=01, ALUSrcB=10, PCWrite; add.
- ALU decode (3-bit):
  - ALUOp add → 000; sub → 001.
  - ALUOp funct uses `funct3`:
    - 000 → 001 if `op[5]` & `funct7b5`, else 000.
    - 010 → 101 (slt).
    - 110 → 011 (or).
    - 111 → 010 (and).
    - Any other → 000.
- `ImmSrc` is combinational from `op`: S → 01, B → 10, J → 11, otherwise 00.

## Timing
- State register only; every output is combinational from `state`, plus `op`/`funct*`/`Zero` where listed.
- Cycles per instruction: lw 5, sw 4, R/I 4, jal 4, beq 3, illegal 2.
- While `rst`=0:
  - `state`=FETCH on the next edge.
  - PCWrite, IRWrite, RegWrite, MemWrite and `illegal` are forced to 0 combinationally.
  - Selects hold their FETCH values.
- Reset asserted mid-instruction aborts it. No write enable is asserted in the cycle in which `rst` is low.
- After `rst` is released, the first edge performs the FETCH action at PC=reset value.
- PCWrite in BEQ depends combinationally on `Zero` in the same cycle. There is no registered branch decision.

## Configuration
- `MCCTRL_JAL_EN` defined: the JAL state and transition are compiled in.
- Undefined: opcode 1101111 decodes as illegal (DECODE → FETCH, `illegal` pulse). State 10 is then unreachable and falls to FETCH.

## Structure
- Package `riscv_pkg` holds:
  - the state enum;
  - opcode localparams (OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL);
  - ALUControl codes;
  - ImmSrc codes;
  - the ResultSrc/ALUSrcA/ALUSrcB select encodings.
- One sub-module, `alu_decoder` (ALUOp, funct3, op5, funct7b5 → ALUControl). It is shared with the single-cycle `control`.

## Test plan
- Reset: hold `rst`=0 for 3 cycles from a random state → `state`=0, all four write enables 0 throughout. Release → IRWrite=1 and PCWrite=1 on the first cycle.
- lw (op 0000011) → states 0,1,2,3,4. RegWrite only in state 4 with ResultSrc=01; AdrSrc=1 in state 3.
- sw (op 0100011) → states 0,1,2,5. MemWrite=1 only in state 5; ImmSrc=01 throughout.
- R-type sub (funct3 000, funct7b5 1) → ALUControl=001 in EXECR. Same fields with op 0010011 (addi) → 000.
- beq with Zero=1 → PCWrite=1 in state 9. With Zero=0 → PCWrite=0; next state 0 in both cases.
- Opcode 1111111 → `illegal`=1 for one cycle in state 1, then state 0; no RegWrite/MemWrite. Opcode 1101111 gives the same result with `MCCTRL_JAL_EN` undefined, and states 0,1,10,8 with it defined.
